// File: rtl/cpu_fpu_add_arbiter_pkg.sv
// Shared types and constants for the FPU add arbitration slice.
package cpu_fpu_add_arbiter_pkg;

  localparam int FP_W        = 32;
  localparam int FP_SIGN_BIT = 31;

  // Arbiter sequencing around one adder operation
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } fpu_arb_state_t;

  // Adder-side handshake states, as seen by anything sharing the adder
  typedef enum logic [1:0] {
    FPU_IDLE = 2'd0,
    FPU_BUSY = 2'd1,
    FPU_DONE = 2'd2
  } fpu_add_state_t;

  // Conditionally flip the IEEE-754 sign; applies to every encoding (NaN/Inf/zero too)
  function automatic logic [FP_W-1:0] fp_neg_if(input logic [FP_W-1:0] v, input logic neg);
    fp_neg_if = {v[FP_SIGN_BIT] ^ neg, v[FP_SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/cpu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module cpu_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               valid_o
);

  int             idx;
  logic [IDX_W-1:0] sel;

  // Scan NUM_REQ positions starting at the pointer; the first hit wins
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDX_W'(idx);
      if (!valid_o && req_i[sel]) begin
        valid_o = 1'b1;
        grant_o = sel;
      end
    end
  end

endmodule

// File: rtl/cpu_fpu_add_arbiter.sv
// Shares one multi-cycle FP adder among NUM_REQ requesters, round-robin,
// with per-requester subtract done by flipping the op2 sign bit.
module cpu_fpu_add_arbiter
  import cpu_fpu_add_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_request,
  input  logic [NUM_REQ*32-1:0] i_op1,
  input  logic [NUM_REQ*32-1:0] i_op2,
  input  logic [NUM_REQ-1:0]    i_sub,
  output logic [NUM_REQ-1:0]    o_ready,
  output logic [31:0]           o_result,
  output logic                  o_fpu_request,
  output logic [31:0]           o_fpu_op1,
  output logic [31:0]           o_fpu_op2,
  input  logic                  i_fpu_ready,
  input  logic [31:0]           i_fpu_result,
  output logic                  o_busy
);

  fpu_arb_state_t       state_q;
  logic [IDX_W-1:0]     grant_q, ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   ready_q, grant_oh;
  logic [31:0]          result_q, op1_q, op2_q;
  logic                 fpu_req_q;

  logic [IDX_W-1:0]     pick_grant;
  logic                 pick_vld;
  logic [31:0]          op1_a [NUM_REQ];
  logic [31:0]          op2_a [NUM_REQ];
  logic [31:0]          win_op2;

  // Unpack the flat operand buses into per-requester words
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op1_a[k] = i_op1[32*k +: 32];
    assign op2_a[k] = i_op2[32*k +: 32];
  end

  cpu_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i   (i_request),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_vld)
  );

  // Winner's op2 with subtract folded into the sign bit
  always_comb win_op2 = fp_neg_if(op2_a[pick_grant], i_sub[pick_grant]);

  // Pointer advances to the slot after the finished grant, wrapping
  always_comb ptr_d = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

  // One-hot completion vector for the current grant
  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  // Arbitration FSM; every output comes straight from a register here
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      ready_q   <= '0;
      result_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      fpu_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Adder ready while idle is a protocol error and is ignored
          if (pick_vld) begin
            grant_q   <= pick_grant;
            op1_q     <= op1_a[pick_grant];
            op2_q     <= win_op2;
            fpu_req_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          // Requester dropping here does not abort the adder
          if (i_fpu_ready) begin
            result_q  <= i_fpu_result;
            fpu_req_q <= 1'b0;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!i_fpu_ready) begin
            if (i_request[grant_q]) begin
              ready_q <= grant_oh;
              state_q <= RESPOND;
            end else begin
              // Abandoned: result discarded, move on
              ptr_q   <= ptr_d;
              state_q <= IDLE;
            end
          end
        end
        RESPOND: begin
          if (!i_request[grant_q]) begin
            ready_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready       = ready_q;
  assign o_result      = result_q;
  assign o_fpu_request = fpu_req_q;
  assign o_fpu_op1     = op1_q;
  assign o_fpu_op2     = op2_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_fpu_add_arbiter.sv
// Directed bench for cpu_fpu_add_arbiter with a small four-phase adder model.
module tb_cpu_fpu_add_arbiter;

  localparam int N   = 2;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_r [N];
  logic [31:0]   op1_r [N];
  logic [31:0]   op2_r [N];
  logic          sub_r [N];
  logic [N-1:0]  i_request, i_sub, o_ready;
  logic [N*32-1:0] i_op1, i_op2;
  logic [31:0]   o_result, o_fpu_op1, o_fpu_op2, fpu_result;
  logic          o_fpu_request, fpu_ready, o_busy;

  assign i_request = {req_r[1], req_r[0]};
  assign i_sub     = {sub_r[1], sub_r[0]};
  assign i_op1     = {op1_r[1], op1_r[0]};
  assign i_op2     = {op2_r[1], op2_r[0]};

  always #5 clk = ~clk;

  cpu_fpu_add_arbiter #(.NUM_REQ(N)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_request     (i_request),
    .i_op1         (i_op1),
    .i_op2         (i_op2),
    .i_sub         (i_sub),
    .o_ready       (o_ready),
    .o_result      (o_result),
    .o_fpu_request (o_fpu_request),
    .o_fpu_op1     (o_fpu_op1),
    .o_fpu_op2     (o_fpu_op2),
    .i_fpu_ready   (fpu_ready),
    .i_fpu_result  (fpu_result),
    .o_busy        (o_busy)
  );

  // Adder model: hand-computed sums for the operand pairs used below
  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: fp_sum = 32'h40400000; // 1 + 2
      {32'h40400000, 32'hBF800000}: fp_sum = 32'h40000000; // 3 + -1
      {32'h40400000, 32'hC0400000}: fp_sum = 32'h00000000; // 3 + -3
      default:                      fp_sum = 32'h7FC00000;
    endcase
  endfunction

  int          fst, fcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fst <= 0; fcnt <= 0; fpu_ready <= 1'b0; fpu_result <= '0;
    end else begin
      case (fst)
        0: if (o_fpu_request) begin fcnt <= LAT; fst <= 1; end
        1: if (fcnt == 1) begin
             fpu_ready  <= 1'b1;
             fpu_result <= fp_sum(o_fpu_op1, o_fpu_op2);
             fst        <= 2;
           end else fcnt <= fcnt - 1;
        default: if (!o_fpu_request) begin fpu_ready <= 1'b0; fst <= 0; end
      endcase
    end
  end

  // Completion monitor: rises per requester and grant order
  logic [N-1:0] rdy_prev = '0;
  int           rdy_rise [N];
  int           gq [$];
  always @(negedge clk) begin
    for (int k = 0; k < N; k++)
      if (o_ready[k] && !rdy_prev[k]) begin
        rdy_rise[k] = rdy_rise[k] + 1;
        gq.push_back(k);
      end
    rdy_prev = o_ready;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One requester transaction: raise, optionally check issue, wait for ready, drop
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] exp, input bit chk_iss,
                       input logic [31:0] exp_op2, input string tag);
    int n;
    op1_r[k] = a; op2_r[k] = b; sub_r[k] = s; req_r[k] = 1'b1;
    if (chk_iss) begin
      @(negedge clk);
      chk({tag, "_freq"}, {31'b0, o_fpu_request}, 32'd1);
      chk({tag, "_op1"}, o_fpu_op1, a);
      chk({tag, "_op2"}, o_fpu_op2, exp_op2);
    end
    n = 0;
    while (!o_ready[k] && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, {30'b0, o_ready}, 32'(1 << k));
    chk({tag, "_res"}, o_result, exp);
    req_r[k] = 1'b0;
    n = 0;
    while (o_ready[k] && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rdyfall"}, {31'b0, o_ready[k]}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, r0;
    for (int k = 0; k < N; k++) begin
      req_r[k] = 1'b0; op1_r[k] = '0; op2_r[k] = '0; sub_r[k] = 1'b0; rdy_rise[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", {30'b0, o_ready}, 32'd0);
    chk("rst_freq",  {31'b0, o_fpu_request}, 32'd0);
    chk("rst_res",   o_result, 32'd0);
    chk("rst_op1",   o_fpu_op1, 32'd0);
    chk("rst_op2",   o_fpu_op2, 32'd0);
    chk("rst_busy",  {31'b0, o_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single add on requester 0
    do_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b1, 32'h40000000, "add");
    chk("add_no_rdy1", 32'(rdy_rise[1]), 32'd0);

    // Subtract on requester 1
    do_op(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b1, 32'hBF800000, "sub");

    // Cancellation to +0
    do_op(0, 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b1, 32'hC0400000, "cancel");

    // Contention from reset: both requesting on the same edge, re-requesting at once
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gq.delete();
    fork
      begin
        do_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 32'h0, "ct0a");
        do_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 32'h0, "ct0b");
      end
      begin
        do_op(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 32'h0, "ct1a");
        do_op(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 32'h0, "ct1b");
      end
    join
    chk("ct_cnt", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      chk("ct_g0", 32'(gq[0]), 32'd0);
      chk("ct_g1", 32'(gq[1]), 32'd1);
      chk("ct_g2", 32'(gq[2]), 32'd0);
      chk("ct_g3", 32'(gq[3]), 32'd1);
    end

    // Abandon: req0 drops during ISSUE, req1 arrives mid-op and is served next
    @(negedge clk);
    r0 = rdy_rise[0];
    op1_r[0] = 32'h3F800000; op2_r[0] = 32'h40000000; sub_r[0] = 1'b0; req_r[0] = 1'b1;
    n = 0;
    while (!o_fpu_request && n < 20) begin @(negedge clk); n++; end
    chk("abn_iss", {31'b0, o_fpu_request}, 32'd1);
    chk("abn_op1", o_fpu_op1, 32'h3F800000);
    op1_r[1] = 32'h40400000; op2_r[1] = 32'h3F800000; sub_r[1] = 1'b1; req_r[1] = 1'b1;
    req_r[0] = 1'b0;
    n = 0;
    while (!fpu_ready && n < 50) begin @(negedge clk); n++; end
    chk("abn_fready", {31'b0, fpu_ready}, 32'd1);
    @(negedge clk);
    chk("abn_freq_fall", {31'b0, o_fpu_request}, 32'd0);
    do_op(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 32'h0, "abn_r1");
    chk("abn_no_rdy0", 32'(rdy_rise[0]), 32'(r0));

    // Asynchronous reset in the middle of ISSUE
    @(negedge clk);
    r0 = rdy_rise[0];
    op1_r[0] = 32'h3F800000; op2_r[0] = 32'h40000000; sub_r[0] = 1'b0; req_r[0] = 1'b1;
    n = 0;
    while (!o_fpu_request && n < 20) begin @(negedge clk); n++; end
    chk("mrst_iss", {31'b0, o_fpu_request}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_freq", {31'b0, o_fpu_request}, 32'd0);
    chk("mrst_rdy",  {30'b0, o_ready}, 32'd0);
    chk("mrst_busy", {31'b0, o_busy}, 32'd0);
    req_r[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_no_rdy0", 32'(rdy_rise[0]), 32'(r0));
    do_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b1, 32'h40000000, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
